// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the IMEM READ/BUSYWAIT handshake and
// presents a registered INSTRUCTION/PC/PC_PLUS_4 triple. Define IF_SKID_BUFFER_EN for a skid buffer.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic        IMEM_READ,
   output logic [31:0] IMEM_ADDRESS,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC,
   output logic [31:0] PC_PLUS_4,
   output logic        VALID
);

   typedef enum logic [1:0] {StIdle, StReq, StSquash, StHold} state_e;

   state_e      r_state;
   logic [31:0] r_fetch_pc;
   logic        r_imem_read;
   logic [31:0] r_imem_addr;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_pc4;
   logic        r_valid;

   state_e      w_state_d;
   logic [31:0] w_fetch_pc_d;
   logic        w_imem_read_d;
   logic [31:0] w_imem_addr_d;
   logic [31:0] w_instr_d;
   logic [31:0] w_pc_d;
   logic [31:0] w_pc4_d;
   logic        w_valid_d;
   logic        w_done;
   logic        w_out_free;

`ifdef IF_SKID_BUFFER_EN
   // Buffer contents are only meaningful while in StHold.
   logic [31:0] r_buf_instr;
   logic [31:0] r_buf_pc;
   logic [31:0] w_buf_instr_d;
   logic [31:0] w_buf_pc_d;
`endif

   always_comb begin
      w_done        = r_imem_read & ~IMEM_BUSYWAIT;
      w_out_free    = ~r_valid | ~STALL;
      w_state_d     = r_state;
      w_fetch_pc_d  = r_fetch_pc;
      w_valid_d     = r_valid & STALL;
      w_instr_d     = (r_valid & STALL) ? r_instr : NOP_INSTR;
      w_pc_d        = r_pc;
      w_pc4_d       = r_pc4;
`ifdef IF_SKID_BUFFER_EN
      w_buf_instr_d = r_buf_instr;
      w_buf_pc_d    = r_buf_pc;
`endif

      if (BRANCH_TAKEN) begin
         w_fetch_pc_d = {BRANCH_TARGET[31:2], 2'b00};
         w_valid_d    = 1'b0;
         w_instr_d    = NOP_INSTR;
         // An in-flight access must finish before a new address may be presented.
         w_state_d    = (r_imem_read & IMEM_BUSYWAIT) ? StSquash : StReq;
      end else begin
         case (r_state)
            StIdle: w_state_d = StReq;
            StReq: begin
               if (w_done) begin
                  if (w_out_free) begin
                     w_instr_d    = IMEM_READDATA;
                     w_pc_d       = r_fetch_pc;
                     w_pc4_d      = r_fetch_pc + 32'd4;
                     w_valid_d    = 1'b1;
                     w_fetch_pc_d = r_fetch_pc + 32'd4;
                  end else begin
`ifdef IF_SKID_BUFFER_EN
                     w_buf_instr_d = IMEM_READDATA;
                     w_buf_pc_d    = r_fetch_pc;
                     w_fetch_pc_d  = r_fetch_pc + 32'd4;
`endif
                     // Without the buffer the data is dropped and the address replayed.
                     w_state_d = StHold;
                  end
               end
            end
            StSquash: begin
               if (w_done) w_state_d = StReq;
            end
            StHold: begin
               if (!STALL) begin
`ifdef IF_SKID_BUFFER_EN
                  w_instr_d = r_buf_instr;
                  w_pc_d    = r_buf_pc;
                  w_pc4_d   = r_buf_pc + 32'd4;
                  w_valid_d = 1'b1;
`endif
                  w_state_d = StReq;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end

      w_imem_read_d = (w_state_d == StReq) || (w_state_d == StSquash);
      w_imem_addr_d = (w_state_d == StSquash) ? r_imem_addr : w_fetch_pc_d;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= StIdle;
         r_fetch_pc  <= RESET_PC;
         r_imem_read <= 1'b0;
         r_imem_addr <= RESET_PC;
         r_instr     <= NOP_INSTR;
         r_pc        <= 32'd0;
         r_pc4       <= 32'd0;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_fetch_pc  <= w_fetch_pc_d;
         r_imem_read <= w_imem_read_d;
         r_imem_addr <= w_imem_addr_d;
         r_instr     <= w_instr_d;
         r_pc        <= w_pc_d;
         r_pc4       <= w_pc4_d;
         r_valid     <= w_valid_d;
      end
   end

`ifdef IF_SKID_BUFFER_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_buf_instr <= NOP_INSTR;
         r_buf_pc    <= 32'd0;
      end else begin
         r_buf_instr <= w_buf_instr_d;
         r_buf_pc    <= w_buf_pc_d;
      end
   end
`endif

   assign IMEM_READ    = r_imem_read;
   assign IMEM_ADDRESS = r_imem_addr;
   assign INSTRUCTION  = r_instr;
   assign PC           = r_pc;
   assign PC_PLUS_4    = r_pc4;
   assign VALID        = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with variable latency plus a program-order model of
// the consumed instruction stream (sequential PCs, restarted by redirects and reset).
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] br_tgt = 32'd0;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_busy = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        valid;

   if_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .CLK           (CLK),
      .RESET         (rst_n),
      .STALL         (stall),
      .BRANCH_TAKEN  (br),
      .BRANCH_TARGET (br_tgt),
      .IMEM_READ     (imem_read),
      .IMEM_ADDRESS  (imem_addr),
      .IMEM_READDATA (imem_rdata),
      .IMEM_BUSYWAIT (imem_busy),
      .INSTRUCTION   (instr),
      .PC            (pc),
      .PC_PLUS_4     (pc4),
      .VALID         (valid)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_err = 0;
   bit          req_active = 0;
   int          wait_left = 0;
   logic [31:0] held_addr = 32'd0;
   bit          rand_lat = 0;
   int          fix_lat = 0;
   logic [31:0] exp_pc = RESET_PC;
   int          n_consumed = 0;
   logic [31:0] snap_pc, snap_instr;
   bit          found;
   int          c0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive the memory response, score the coming edge, then advance past it.
   task automatic tick();
      if (imem_read) begin
         if (!req_active) begin
            req_active = 1;
            wait_left  = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
            held_addr  = imem_addr;
         end else begin
            chk("addr_stable", imem_addr, held_addr);
         end
      end
      imem_busy  = imem_read && (wait_left != 0);
      imem_rdata = (imem_read && !imem_busy) ? mem_data(imem_addr) : $urandom;
      if (!valid) chk("nop_when_invalid", instr, NOP);
      if (!br && valid && !stall) begin
         chk("pc", pc, exp_pc);
         chk("instr", instr, mem_data(exp_pc));
         chk("pc_plus_4", pc4, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
         n_consumed++;
      end
      @(posedge CLK);
      #1;
      if (req_active) begin
         if (imem_busy) wait_left--;
         else req_active = 0;
      end
      if (br) begin
         exp_pc = {br_tgt[31:2], 2'b00};
         chk("valid_after_redirect", {31'd0, valid}, 32'd0);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_busy  = 1'b0;
      req_active = 0;
      wait_left  = 0;
      exp_pc     = RESET_PC;
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      chk("rst_read", {31'd0, imem_read}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      @(posedge CLK);
      @(negedge CLK);
      rst_n = 1'b1;
      @(posedge CLK);
      #1;
      chk("start_read", {31'd0, imem_read}, 32'd1);
      chk("start_addr", imem_addr, RESET_PC);
      chk("start_valid", {31'd0, valid}, 32'd0);
   endtask

   initial begin
      // Zero-wait startup: back-to-back fetch from RESET_PC.
      #1;
      fix_lat = 0;
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("b2b_valid", {31'd0, valid}, 32'd1);
         chk("b2b_pc", pc, RESET_PC + 32'(i * 4));
         chk("b2b_instr", instr, mem_data(RESET_PC + 32'(i * 4)));
         tick();
      end

      // Three wait states per access.
      fix_lat = 3;
      c0 = n_consumed;
      repeat (30) tick();
      chk("progress_wait3", {31'd0, (n_consumed - c0) >= 5}, 32'd1);

      // Redirect to 0x43 while the fetch of 0x8 is waiting.
      do_reset();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (imem_read && imem_addr == 32'h8) found = 1;
      end
      chk("reach_fetch_8", {31'd0, found}, 32'd1);
      tick();
      br = 1'b1;
      br_tgt = 32'h43;
      tick();
      br = 1'b0;
      chk("squash_addr", imem_addr, 32'h8);
      chk("squash_read", {31'd0, imem_read}, 32'd1);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (imem_read && imem_addr != 32'h8) found = 1;
      end
      chk("redirect_seen", {31'd0, found}, 32'd1);
      chk("redirect_addr", imem_addr, 32'h40);
      for (int i = 0; i < 10 && !valid; i++) tick();
      chk("redirect_pc", pc, 32'h40);
      chk("redirect_instr", instr, mem_data(32'h40));

      // Four-cycle stall mid-stream: presented triple frozen.
      fix_lat = 0;
      for (int i = 0; i < 10 && !valid; i++) tick();
      tick();
      chk("pre_stall_valid", {31'd0, valid}, 32'd1);
      snap_pc    = pc;
      snap_instr = instr;
      stall = 1'b1;
      repeat (4) begin
         tick();
         chk("stall_valid", {31'd0, valid}, 32'd1);
         chk("stall_pc", pc, snap_pc);
         chk("stall_instr", instr, snap_instr);
      end
      stall = 1'b0;
      repeat (10) tick();

      // Reset in the middle of a waiting access.
      fix_lat = 3;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (imem_read && req_active && wait_left > 0) found = 1;
      end
      chk("mid_wait_reached", {31'd0, found}, 32'd1);
      do_reset();
      repeat (12) tick();

      // Fetch PC wrap-around.
      fix_lat = 0;
      br = 1'b1;
      br_tgt = 32'hFFFF_FFFE;
      tick();
      br = 1'b0;
      for (int i = 0; i < 10 && !valid; i++) tick();
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc4, 32'h0);
      tick();
      chk("wrap_next_pc", pc, 32'h0);
      chk("wrap_next_pc4", pc4, 32'h4);

      // Randomized traffic.
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         stall  = ($urandom_range(0, 9) < 3);
         br     = ($urandom_range(0, 24) == 0);
         br_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
         tick();
      end
      br = 1'b0;
      stall = 1'b0;
      c0 = n_consumed;
      repeat (20) tick();
      chk("drain_progress", {31'd0, n_consumed > c0}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RV32IM pipeline, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the instruction-memory read handshake (READ/BUSYWAIT).
- Presents a registered INSTRUCTION / PC / PC_PLUS_4 triple for IF/ID to capture.
- Honours hazard-unit STALL and EX-stage branch/jump redirects, squashing wrong-path fetches.

Parameters:
RESET_PC, 32'h00000000, first address fetched after reset
NOP_INSTR, 32'h00000013, instruction driven while output not valid (addi x0,x0,0)

Ports:
CLK  input  1  pipeline clock, rising edge
RESET  input  1  asynchronous, active-low reset
STALL  input  1  hazard unit holds IF/ID; presented output not consumed this edge
BRANCH_TAKEN  input  1  EX-stage redirect request
BRANCH_TARGET  input  32  redirect address; bits[1:0] forced to 0
IMEM_READ  output  1  instruction-memory read request
IMEM_ADDRESS  output  32  read address; stable while IMEM_READ=1
IMEM_READDATA  input  32  read data; valid in the cycle IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  input  1  memory busy; request completes at rising edge with IMEM_READ=1, IMEM_BUSYWAIT=0
INSTRUCTION  output  32  fetched instruction, NOP_INSTR when VALID=0
PC  output  32  address of INSTRUCTION
PC_PLUS_4  output  32  PC+4, modulo 2^32
VALID  output  1  presented triple holds a real instruction

Behaviour:
- Reset (RESET=0, async): state IDLE, fetch_pc=RESET_PC, IMEM_READ=0, IMEM_ADDRESS=RESET_PC, INSTRUCTION=NOP_INSTR, PC=0, PC_PLUS_4=0, VALID=0, buffer empty. Reset mid-request abandons it; no data is kept.
- All outputs are registered; IMEM_ADDRESS=fetch_pc, except in SQUASH.
- Consume rule: the presented triple is consumed at any edge with STALL=0. VALID drops to 0 after consumption unless new data loads on the same edge.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: IMEM_READ=1. On completion, if output is empty or being consumed: load INSTRUCTION=IMEM_READDATA, PC=fetch_pc, PC_PLUS_4=fetch_pc+4, VALID=1; fetch_pc+=4; stay in REQ (back-to-back fetch, no bubble with a zero-wait memory).
  - Completion while output is full and STALL=1: see Optional Feature.
  - SQUASH: IMEM_READ=1 with the old address held until completion; data discarded; then REQ at the redirected fetch_pc.
- Redirect (BRANCH_TAKEN=1 at edge, priority over STALL and completion):
  - fetch_pc<=BRANCH_TARGET & ~3; VALID<=0; INSTRUCTION<=NOP_INSTR; buffer cleared.
  - If a request is outstanding and not completing this edge, go to SQUASH; otherwise go to REQ.
- Redirect while in SQUASH: update fetch_pc only; stay in SQUASH.
- fetch_pc wraps 0xFFFFFFFC -> 0x00000000.

Optional Feature:
Macro: IF_SKID_BUFFER_EN
- Defined: one-entry skid buffer (instr + pc). Completion with output full and STALL=1 captures into the buffer; fetch_pc+=4; IMEM_READ=0 while the buffer is full. At the first edge with STALL=0, buffer moves to the outputs and REQ resumes next cycle. Redirect clears the buffer.
- Undefined: the same completion is dropped; fetch_pc unchanged; IMEM_READ deasserts until STALL=0, then the same address is re-requested (replay). No instruction is lost or duplicated in either build.

Test Plan:
- Reset release, zero-wait memory returning addr+0x100: VALID=1 one cycle after first completion; PC sequence 0,4,8,C; PC_PLUS_4=PC+4; INSTRUCTION=0x100,0x104,...
- Memory BUSYWAIT=1 for 3 cycles per access: IMEM_ADDRESS stable during wait; each instruction presented exactly once, in order.
- BRANCH_TAKEN with target 0x43 during an outstanding 3-cycle fetch of 0x8: VALID=0 next edge; 0x8 data discarded; next IMEM_ADDRESS=0x40; PC=0x40 presented.
- STALL high 4 cycles mid-stream: outputs frozen; after release, sequence continues with no gap or duplicate (run both with and without IF_SKID_BUFFER_EN).
- RESET pulsed low mid-wait: outputs immediately NOP_INSTR/0/0/VALID=0; restart fetch at RESET_PC.
- fetch_pc at 0xFFFFFFFC: PC_PLUS_4=0; next fetch address 0x0.
